// File: rtl/usb_data_buffer.sv
// usb_data_buffer: 64-byte shared byte FIFO between the AHB slave side and the
// USB RX/TX packet engines. Two producers and two consumers share one queue.
// Head byte is shown ahead to both consumers, and occupancy is reported.
//
// Strobe semantics: a push strobe writes its byte at the rising edge if there
// is room, or if a pop is accepted in the same cycle. A pop strobe consumes the
// byte shown on RX_Data/TX_Packet_Data in that cycle, if one exists. There is
// no backpressure. A rejected strobe is reported one cycle later on overflow or
// underflow. Two pushes or two pops in the same cycle are reported on collision.
module usb_data_buffer #(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 8,
   parameter int OCC_W  = 7
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              Clear,
   input  logic              Store_TX_Data,
   input  logic [DATA_W-1:0] TX_Data,
   input  logic              Store_RX_Packet_Data,
   input  logic [DATA_W-1:0] RX_Packet_Data,
   input  logic              Get_RX_Data,
   output logic [DATA_W-1:0] RX_Data,
   input  logic              Get_TX_Packet_Data,
   output logic [DATA_W-1:0] TX_Packet_Data,
   output logic [OCC_W-1:0]  Buffer_Occupancy,
   output logic              overflow,
   output logic              underflow,
   output logic              collision
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rptr;
   logic [PTR_W-1:0]  wptr;
   logic [OCC_W-1:0]  occ;

   logic              push;
   logic              pop;
   logic              push_ok;
   logic              pop_ok;
   logic              empty;
   logic              full;
   logic [DATA_W-1:0] push_data;
   logic [DATA_W-1:0] head;

   // Arbitration: the RX engine wins the write port, and one pop serves both consumers.
   always_comb begin
      push      = Store_TX_Data | Store_RX_Packet_Data;
      push_data = Store_RX_Packet_Data ? RX_Packet_Data : TX_Data;
      pop       = Get_RX_Data | Get_TX_Packet_Data;
      empty     = (occ == '0);
      full      = (occ == OCC_W'(DEPTH));
      pop_ok    = pop && !empty;
      // A full buffer still takes a push when a pop frees a slot in the same edge.
      push_ok   = push && (!full || pop_ok);
      head      = empty ? '0 : mem[rptr];
   end

   assign RX_Data          = head;
   assign TX_Packet_Data   = head;
   assign Buffer_Occupancy = occ;

   // Pointer, occupancy and error-pulse state. Clear flushes without touching storage.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rptr      <= '0;
         wptr      <= '0;
         occ       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         collision <= 1'b0;
      end else if (Clear) begin
         rptr      <= '0;
         wptr      <= '0;
         occ       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         collision <= 1'b0;
      end else begin
         if (push_ok) begin
            wptr <= wptr + 1'b1;
         end
         if (pop_ok) begin
            rptr <= rptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
         overflow  <= push && !push_ok;
         underflow <= pop && !pop_ok;
         collision <= (Store_TX_Data && Store_RX_Packet_Data) ||
                      (Get_RX_Data && Get_TX_Packet_Data);
      end
   end

   // Byte storage: written at wptr on an accepted push. Only reset clears it.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (!Clear && push_ok) begin
         mem[wptr] <= push_data;
      end
   end

endmodule

// File: tb/tb_usb_data_buffer.sv
// tb_usb_data_buffer: randomized and directed stimulus for usb_data_buffer.
// The reference model is a byte queue plus the accept/reject rules.
module tb_usb_data_buffer;

   localparam int DEPTH = 64;

   logic       clk;
   logic       n_rst;
   logic       Clear;
   logic       Store_TX_Data;
   logic [7:0] TX_Data;
   logic       Store_RX_Packet_Data;
   logic [7:0] RX_Packet_Data;
   logic       Get_RX_Data;
   logic [7:0] RX_Data;
   logic       Get_TX_Packet_Data;
   logic [7:0] TX_Packet_Data;
   logic [6:0] Buffer_Occupancy;
   logic       overflow;
   logic       underflow;
   logic       collision;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_q[$];

   usb_data_buffer #(.DEPTH(64), .DATA_W(8), .OCC_W(7)) dut (
      .clk                  (clk),
      .n_rst                (n_rst),
      .Clear                (Clear),
      .Store_TX_Data        (Store_TX_Data),
      .TX_Data              (TX_Data),
      .Store_RX_Packet_Data (Store_RX_Packet_Data),
      .RX_Packet_Data       (RX_Packet_Data),
      .Get_RX_Data          (Get_RX_Data),
      .RX_Data              (RX_Data),
      .Get_TX_Packet_Data   (Get_TX_Packet_Data),
      .TX_Packet_Data       (TX_Packet_Data),
      .Buffer_Occupancy     (Buffer_Occupancy),
      .overflow             (overflow),
      .underflow            (underflow),
      .collision            (collision)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, check the head, then check registered results.
   task automatic step(input logic clr, input logic stx, input logic [7:0] txd,
                       input logic srx, input logic [7:0] rxd,
                       input logic grx, input logic gtx);
      logic [7:0] exp_head;
      logic [7:0] d;
      bit push, pop, pop_ok, push_ok;
      bit exp_ovf, exp_udf, exp_col;
      @(negedge clk);
      Clear                = clr;
      Store_TX_Data        = stx;
      TX_Data              = txd;
      Store_RX_Packet_Data = srx;
      RX_Packet_Data       = rxd;
      Get_RX_Data          = grx;
      Get_TX_Packet_Data   = gtx;
      #1;
      exp_head = (exp_q.size() == 0) ? 8'h00 : exp_q[0];
      chk("rx_data", 32'(RX_Data), 32'(exp_head));
      chk("tx_packet_data", 32'(TX_Packet_Data), 32'(exp_head));
      exp_ovf = 0; exp_udf = 0; exp_col = 0;
      if (clr) begin
         exp_q.delete();
      end else begin
         push    = stx || srx;
         d       = srx ? rxd : txd;
         pop     = grx || gtx;
         pop_ok  = pop && (exp_q.size() > 0);
         push_ok = push && ((exp_q.size() < DEPTH) || pop_ok);
         if (pop_ok) void'(exp_q.pop_front());
         if (push_ok) exp_q.push_back(d);
         exp_ovf = push && !push_ok;
         exp_udf = pop && !pop_ok;
         exp_col = (stx && srx) || (grx && gtx);
      end
      @(posedge clk);
      #1;
      chk("occupancy", 32'(Buffer_Occupancy), exp_q.size());
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("underflow", 32'(underflow), 32'(exp_udf));
      chk("collision", 32'(collision), 32'(exp_col));
   endtask

   task automatic idle();
      step(0, 0, 8'h00, 0, 8'h00, 0, 0);
   endtask

   // Asynchronous reset pulse in the middle of a cycle.
   task automatic async_reset();
      @(negedge clk);
      Clear = 0; Store_TX_Data = 0; Store_RX_Packet_Data = 0;
      Get_RX_Data = 0; Get_TX_Packet_Data = 0;
      #2 n_rst = 1'b0;
      #1;
      exp_q.delete();
      chk("async_rst_occ", 32'(Buffer_Occupancy), 32'd0);
      chk("async_rst_head", 32'(RX_Data), 32'd0);
      chk("async_rst_flags", {29'd0, overflow, underflow, collision}, 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   // Stimulus and final report.
   initial begin
      int p_push, p_pop;
      logic [7:0] bytes3 [3];
      n_rst = 1'b0;
      Clear = 0; Store_TX_Data = 0; TX_Data = 0; Store_RX_Packet_Data = 0;
      RX_Packet_Data = 0; Get_RX_Data = 0; Get_TX_Packet_Data = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_occ", 32'(Buffer_Occupancy), 32'd0);
      chk("reset_rx_data", 32'(RX_Data), 32'd0);
      chk("reset_tx_data", 32'(TX_Packet_Data), 32'd0);
      chk("reset_flags", {29'd0, overflow, underflow, collision}, 32'd0);
      @(negedge clk);
      n_rst = 1'b1;

      // Three TX-side bytes, drained by the TX engine.
      bytes3[0] = 8'hA1; bytes3[1] = 8'hB2; bytes3[2] = 8'hC3;
      for (int i = 0; i < 3; i++) step(0, 1, bytes3[i], 0, 8'h00, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 8'h00, 0, 1);
      idle();

      // Fill from RX, overflow once, drain from the AHB side.
      for (int i = 0; i < 64; i++) step(0, 0, 8'h00, 1, 8'(i), 0, 0);
      step(0, 0, 8'h00, 1, 8'hEE, 0, 0);
      for (int i = 0; i < 64; i++) step(0, 0, 8'h00, 0, 8'h00, 1, 0);
      idle();

      // Pointer wrap across the top of the array.
      for (int i = 0; i < 60; i++) step(0, 1, 8'($urandom), 0, 8'h00, 0, 0);
      for (int i = 0; i < 60; i++) step(0, 0, 8'h00, 0, 8'h00, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1, 8'($urandom), 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 0, 8'h00, 1, 0);

      // Full buffer with a push and a pop in the same cycle.
      for (int i = 0; i < 64; i++) step(0, 1, 8'(8'h80 + i), 0, 8'h00, 0, 0);
      step(0, 1, 8'h55, 0, 8'h00, 1, 0);
      for (int i = 0; i < 64; i++) step(0, 0, 8'h00, 0, 8'h00, 0, 1);
      idle();

      // Push collision, then underflow.
      step(0, 1, 8'h11, 1, 8'h22, 0, 0);
      step(0, 0, 8'h00, 0, 8'h00, 1, 1);
      step(0, 0, 8'h00, 0, 8'h00, 1, 0);
      idle();

      // Clear wins over a concurrent push and pop.
      for (int i = 0; i < 20; i++) step(0, 1, 8'($urandom), 0, 8'h00, 0, 0);
      step(1, 1, 8'h99, 0, 8'h00, 1, 0);
      step(0, 1, 8'h77, 0, 8'h00, 0, 0);
      step(0, 0, 8'h00, 0, 8'h00, 1, 0);

      // Reset while the buffer holds data.
      for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 8'($urandom), 0, 0);
      async_reset();
      idle();

      // Random traffic with changing push/pop pressure.
      for (int blk = 0; blk < 30; blk++) begin
         p_push = $urandom_range(10, 90);
         p_pop  = $urandom_range(10, 90);
         for (int i = 0; i < 100; i++) begin
            step($urandom_range(0, 99) < 1,
                 $urandom_range(0, 99) < p_push, 8'($urandom),
                 $urandom_range(0, 99) < p_push, 8'($urandom),
                 $urandom_range(0, 99) < p_pop,
                 $urandom_range(0, 99) < p_pop);
         end
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/usb_data_buffer.md
Name: usb_data_buffer

Overview:
- 64-byte shared byte FIFO between the USB endpoint's AHB slave interface and the USB RX/TX packet engines.
- Producers: the AHB side stores host-written bytes for transmission; the RX engine stores received packet payload.
- Consumers: the AHB side reads received payload; the TX engine drains payload for transmission.
- Reports occupancy to the AHB side and supports a synchronous flush (Clear).

Parameters:
- DEPTH, 64, number of byte entries; must be a power of two.
- DATA_W, 8, entry width in bits.
- OCC_W, 7, occupancy width; must satisfy 2^OCC_W > DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- Clear  in  1  synchronous flush request, level-sensitive.
- Store_TX_Data  in  1  AHB-side push strobe.
- TX_Data  in  DATA_W  AHB-side push byte.
- Store_RX_Packet_Data  in  1  RX-engine push strobe.
- RX_Packet_Data  in  DATA_W  RX-engine push byte.
- Get_RX_Data  in  1  AHB-side pop strobe.
- RX_Data  out  DATA_W  head byte presented to the AHB side (show-ahead).
- Get_TX_Packet_Data  in  1  TX-engine pop strobe.
- TX_Packet_Data  out  DATA_W  head byte presented to the TX engine (show-ahead).
- Buffer_Occupancy  out  OCC_W  number of valid entries, 0..DEPTH.
- overflow  out  1  one-cycle pulse: push dropped because the buffer is full.
- underflow  out  1  one-cycle pulse: pop ignored because the buffer is empty.
- collision  out  1  one-cycle pulse: both pushes or both pops asserted in the same cycle.

Behaviour:
- Reset values: read pointer = 0, write pointer = 0, Buffer_Occupancy = 0, all storage = 0, overflow/underflow/collision = 0.
- Storage: DEPTH x DATA_W register array. Pointers are log2(DEPTH) bits and wrap modulo DEPTH, so 63+1 wraps to 0.
- Show-ahead read:
  - RX_Data and TX_Packet_Data are both combinational from mem[rptr].
  - The consumer samples the byte in the same cycle it asserts its Get strobe.
  - The pointer advances at that clock edge, so the next byte is visible in the following cycle.
  - Both outputs are forced to 0 when Buffer_Occupancy == 0.
- Push arbitration:
  - Store_RX_Packet_Data has priority.
  - If both push strobes are asserted, only the RX byte is written and collision pulses.
- Pop arbitration:
  - Get_RX_Data has priority.
  - If both pop strobes are asserted, exactly one entry is popped and collision pulses.
  - Both consumers see the same head byte that cycle.
- Per-cycle evaluation, in priority order:
  1. Clear = 1: rptr, wptr and Buffer_Occupancy go to 0; push and pop are ignored; no error pulses; storage is not cleared.
  2. Otherwise the effective push is push_ok = push && (occ < DEPTH || pop_ok).
  3. The effective pop is pop_ok = pop && occ > 0.
  4. A push to a full buffer is allowed only when pop_ok is asserted in the same cycle.
- Pointer and occupancy update:
  - push_ok: mem[wptr] <= data; wptr += 1.
  - pop_ok: rptr += 1.
  - occ_next = occ + push_ok - pop_ok.
  - Push and pop in the same cycle leave occupancy unchanged.
- Empty boundary: a push and pop in the same cycle at occ == 0 → pop ignored, underflow = 1, push accepted, occ becomes 1. There is no write-through bypass.
- Full boundary: occ == DEPTH with a push and no pop → byte dropped, overflow = 1, occ stays DEPTH. With a simultaneous pop → both accepted, occ stays DEPTH.
- Error pulses (overflow, underflow, collision):
  - Registered; asserted in the cycle after the offending strobe, for one cycle only.
  - Cleared by reset.
  - Not asserted in a cycle where Clear is active.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); in-flight strobes are lost.
- Buffer_Occupancy is registered: it reflects pushes and pops one cycle after the strobe edge.
- Latency: push to visible at head (when empty) = 1 cycle.

Test Plan:
- Reset, then push 0xA1, 0xB2, 0xC3 via Store_TX_Data → occ = 3; the TX engine pops three times → TX_Packet_Data reads A1, B2, C3 in successive cycles; occ = 0; outputs return to 0.
- RX push of 64 bytes 0x00..0x3F → occ = 64; a 65th push → overflow pulses one cycle, occ stays 64; 64 Get_RX_Data pops → RX_Data reads 0x00..0x3F.
- Pointer wrap: push 60, pop 60, push 10, pop 10 → data order preserved across the index 63 to 0 boundary; occ = 0.
- Full buffer with simultaneous push 0x55 and pop → occ stays 64, the popped byte is the oldest, and 0x55 appears as the last byte drained.
- Store_TX_Data = 0x11 and Store_RX_Packet_Data = 0x22 in the same cycle → collision pulses, only 0x22 is stored, occ = 1. Pop at occ = 0 → underflow pulses, occ stays 0.
- occ = 20, assert Clear together with a push and a pop → occ = 0 next cycle, no error pulses; a subsequent push of 0x77 reads back 0x77 first.
